fifo_uart_tx: RTL and testbench

Drain stage that sits directly downstream of the camera FIFO. Pops one byte at a time from the FIFO read port and serialises it as 8N1 asynchronous serial (start bit, 8 data bits LSB first, stop bit) on a single `tx` line. It shares its clock with the FIFO read side (`rclk`), and stops requesting data whenever the FIFO reports `empy`.

---
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the camera FIFO one byte at a time and serialises
// each byte as 8N1 asynchronous serial (start, 8 data bits LSB first, stop)
// on the tx line. Runs on the FIFO read clock and only requests a byte while
// enabled and the FIFO reports data available.
module fifo_uart_tx #(
    parameter int dato_width = 8,
    parameter int CLK_DIV    = 434,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empy,
    input  logic [dato_width-1:0] datin,
    output logic                  rd,
    output logic                  tx,
    output logic                  busy,
    output logic [CNT_W-1:0]      sent_cnt
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic              bit_end;

    assign bit_end  = (bit_cnt_q == BIT_LAST);
    assign rd       = rd_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign sent_cnt = sent_cnt_q;

    // Next-state logic; outputs are derived from the next state so that the
    // registered tx/rd/busy line up exactly with the state they belong to.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        sent_cnt_d = sent_cnt_q;

        case (state_q)
            IDLE: begin
                if (en && !empy) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d   = datin[7:0];
                bit_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d  = '0;
                    sent_cnt_d = sent_cnt_q + CNT_W'(1);
                    state_d    = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_d   = (state_d == REQ);
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset; a reset
    // mid-byte simply abandons the byte already popped from the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a small FIFO model and checks
// every cycle against a frame-level reference model, plus directed literal
// checks on decoded bytes, pulse counts and frame timing.
module tb_fifo_uart_tx;

    localparam int D        = 4;
    localparam int CW       = 4;
    localparam int BYTE_CYC = 3 + 10 * D;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          empy;
    logic [7:0]    datin = 8'h00;
    logic          rd;
    logic          tx;
    logic          busy;
    logic [CW-1:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    fifo_uart_tx #(
        .dato_width(8),
        .CLK_DIV(D),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .empy(empy),
        .datin(datin),
        .rd(rd),
        .tx(tx),
        .busy(busy),
        .sent_cnt(sent_cnt)
    );

    // Free-running clock, 10 time units per period
    initial begin
        forever #5 clk = ~clk;
    end

    // Camera FIFO stand-in: bytes pushed by the stimulus, popped on rd with
    // the data presented one cycle later
    logic [7:0] fifoMem [0:63];
    int wrPtr     = 0;
    int fifoRdPtr = 0;
    assign empy = (fifoRdPtr == wrPtr);

    always @(posedge clk) begin
        if (rd === 1'b1) begin
            datin     <= fifoMem[fifoRdPtr & 63];
            fifoRdPtr <= fifoRdPtr + 1;
        end
    end

    // Bit k of a 10-bit 8N1 frame: 0 is start, 1..8 are data LSB first, 9 is stop
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Reference model: a byte occupies the cycles k=1..BYTE_CYC-1 after the
    // IDLE decision; k=1 is the read strobe, frame bits start at k=3
    logic          mActive = 1'b0;
    int            mK      = 0;
    logic [7:0]    mByte   = 8'h00;
    int            mPtr    = 0;
    logic [CW-1:0] mSent   = '0;
    logic          expTx   = 1'b1;
    logic          expRd   = 1'b0;
    logic          expBusy = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mActive = 1'b0;
            mK      = 0;
            mSent   = '0;
        end else if (!mActive) begin
            if (en && (mPtr != wrPtr)) begin
                mActive = 1'b1;
                mK      = 1;
                mByte   = fifoMem[mPtr & 63];
                mPtr    = mPtr + 1;
            end
        end else begin
            mK = mK + 1;
            if (mK == BYTE_CYC) begin
                mActive = 1'b0;
                mSent   = mSent + 1'b1;
            end
        end
        expRd   = mActive && (mK == 1);
        expBusy = mActive;
        if (!mActive || mK < 3) expTx = 1'b1;
        else expTx = frameBit(mByte, (mK - 3) / D);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the reference model
    always @(posedge clk) begin
        #1;
        checkOutput("model tx", {31'b0, tx}, {31'b0, expTx});
        checkOutput("model rd", {31'b0, rd}, {31'b0, expRd});
        checkOutput("model busy", {31'b0, busy}, {31'b0, expBusy});
        checkOutput("model sent_cnt", {28'b0, sent_cnt}, {28'b0, mSent});
    end

    // Monitor: counts rd pulses, stamps busy falls and decodes the serial line
    int         cycle      = 0;
    int         rdCount    = 0;
    int         lastFall   = -1;
    int         rdCycles[$];
    logic [7:0] rxBytes[$];
    logic       prevBusy   = 1'b0;
    logic       rxBusy     = 1'b0;
    int         rxT        = 0;
    logic [7:0] rxSh       = 8'h00;
    int         rxFrameErr = 0;

    always @(posedge clk) begin
        #1;
        cycle = cycle + 1;
        if (rd === 1'b1) begin
            rdCount = rdCount + 1;
            rdCycles.push_back(cycle);
        end
        if (prevBusy && !busy) lastFall = cycle;
        prevBusy = busy;
        if (!rst) begin
            rxBusy = 1'b0;
        end else if (!rxBusy) begin
            if (tx === 1'b0) begin
                rxBusy = 1'b1;
                rxT    = 0;
            end
        end else begin
            rxT = rxT + 1;
            if (rxT >= D + 1 && rxT <= 8 * D + 1 && ((rxT - 1) % D) == 0) begin
                rxSh = {tx, rxSh[7:1]};
            end else if (rxT == 9 * D + 1) begin
                rxBusy = 1'b0;
                if (tx === 1'b1) rxBytes.push_back(rxSh);
                else rxFrameErr = rxFrameErr + 1;
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifoMem[wrPtr] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic resetPulse();
        applyStimulus(1'b0, en);
        waitCycle();
        applyStimulus(1'b1, en);
    endtask

    task automatic waitRdCount(input int target, input int bound);
        for (int i = 0; i < bound && rdCount < target; i++) waitCycle();
        checkOutput("wait rd", rdCount, target);
    endtask

    task automatic waitIdle(input int bound);
        for (int i = 0; i < bound && busy !== 1'b0; i++) waitCycle();
        checkOutput("wait idle", {31'b0, busy}, 32'd0);
    endtask

    // Directed sequence following the test plan
    initial begin
        int base;
        int rxBase;
        int n;
        logic [7:0] exp3 [0:2];
        logic [7:0] wrapBytes [0:16];

        exp3[0] = 8'h00;
        exp3[1] = 8'hFF;
        exp3[2] = 8'h3C;

        rst = 1'b0;
        en  = 1'b1;
        pushByte(8'hA5);
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("reset tx", {31'b0, tx}, 32'd1);
            checkOutput("reset rd", {31'b0, rd}, 32'd0);
            checkOutput("reset busy", {31'b0, busy}, 32'd0);
            checkOutput("reset sent_cnt", {28'b0, sent_cnt}, 32'd0);
        end

        $display("[TB] single byte 0xA5");
        base   = rdCount;
        rxBase = rxBytes.size();
        applyStimulus(1'b1, 1'b1);
        waitRdCount(base + 1, 10);
        waitIdle(60);
        checkOutput("single rd pulses", rdCount - base, 32'd1);
        n = rdCycles.size();
        if (n > 0) checkOutput("single frame cycles", lastFall - (rdCycles[n-1] - 1), 32'd43);
        checkOutput("single rx count", rxBytes.size() - rxBase, 32'd1);
        if (rxBytes.size() > rxBase) checkOutput("single byte", {24'b0, rxBytes[rxBase]}, 32'hA5);
        checkOutput("single sent_cnt", {28'b0, sent_cnt}, 32'd1);

        $display("[TB] back-to-back 00 FF 3C");
        resetPulse();
        base   = rdCount;
        rxBase = rxBytes.size();
        pushByte(8'h00);
        pushByte(8'hFF);
        pushByte(8'h3C);
        waitRdCount(base + 3, 3 * BYTE_CYC + 10);
        waitIdle(60);
        n = rdCycles.size();
        if (n >= 3) begin
            checkOutput("b2b spacing 1", rdCycles[n-2] - rdCycles[n-3], 32'd43);
            checkOutput("b2b spacing 2", rdCycles[n-1] - rdCycles[n-2], 32'd43);
        end
        checkOutput("b2b rx count", rxBytes.size() - rxBase, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (rxBytes.size() > rxBase + i) checkOutput("b2b byte", {24'b0, rxBytes[rxBase+i]}, {24'b0, exp3[i]});
        end
        checkOutput("b2b sent_cnt", {28'b0, sent_cnt}, 32'd3);
        repeat (20) waitCycle();
        checkOutput("b2b hold rd pulses", rdCount - base, 32'd3);
        checkOutput("b2b hold busy", {31'b0, busy}, 32'd0);

        $display("[TB] en gating");
        resetPulse();
        base   = rdCount;
        rxBase = rxBytes.size();
        pushByte(8'h96);
        pushByte(8'h69);
        waitRdCount(base + 1, 10);
        repeat (19) waitCycle();
        applyStimulus(1'b1, 1'b0);
        waitIdle(60);
        repeat (20) waitCycle();
        checkOutput("gate rd pulses", rdCount - base, 32'd1);
        checkOutput("gate busy", {31'b0, busy}, 32'd0);
        checkOutput("gate sent_cnt", {28'b0, sent_cnt}, 32'd1);
        if (rxBytes.size() > rxBase) checkOutput("gate byte 1", {24'b0, rxBytes[rxBase]}, 32'h96);
        applyStimulus(1'b1, 1'b1);
        waitCycle();
        checkOutput("gate resume rd", {31'b0, rd}, 32'd1);
        waitIdle(60);
        checkOutput("gate rx count", rxBytes.size() - rxBase, 32'd2);
        if (rxBytes.size() > rxBase + 1) checkOutput("gate byte 2", {24'b0, rxBytes[rxBase+1]}, 32'h69);
        checkOutput("gate sent_cnt 2", {28'b0, sent_cnt}, 32'd2);

        $display("[TB] reset mid-byte");
        base   = rdCount;
        rxBase = rxBytes.size();
        pushByte(8'h5A);
        pushByte(8'hC3);
        waitRdCount(base + 1, 10);
        repeat (27) waitCycle();
        applyStimulus(1'b0, 1'b1);
        waitCycle();
        checkOutput("midrst tx", {31'b0, tx}, 32'd1);
        checkOutput("midrst busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst sent_cnt", {28'b0, sent_cnt}, 32'd0);
        applyStimulus(1'b1, 1'b1);
        waitRdCount(base + 2, 10);
        waitIdle(60);
        repeat (10) waitCycle();
        checkOutput("midrst rd pulses", rdCount - base, 32'd2);
        checkOutput("midrst rx count", rxBytes.size() - rxBase, 32'd1);
        if (rxBytes.size() > rxBase) checkOutput("midrst byte", {24'b0, rxBytes[rxBase]}, 32'hC3);
        checkOutput("midrst sent_cnt 2", {28'b0, sent_cnt}, 32'd1);

        $display("[TB] sent_cnt wrap, 17 bytes");
        resetPulse();
        base   = rdCount;
        rxBase = rxBytes.size();
        for (int i = 0; i < 17; i++) begin
            wrapBytes[i] = 8'((i * 13 + 5) & 255);
            pushByte(wrapBytes[i]);
        end
        waitRdCount(base + 17, 17 * BYTE_CYC + 20);
        waitIdle(60);
        checkOutput("wrap sent_cnt", {28'b0, sent_cnt}, 32'd1);
        checkOutput("wrap rx count", rxBytes.size() - rxBase, 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (rxBytes.size() > rxBase + i) checkOutput("wrap byte", {24'b0, rxBytes[rxBase+i]}, {24'b0, wrapBytes[i]});
        end
        checkOutput("stop bit errors", rxFrameErr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
